audio_cmd_ctrl: RTL and testbench
=================================

Name: audio_cmd_ctrl

Overview:
Command-driven playback controller between the Bluetooth UART receiver and the music/tone engine. It decodes received bytes into play, loop and stop commands for one of NUM_TRACKS songs. It drives the engine enable and track select, and supports both "cut immediately" and "allow song to finish" stop policies as a parameter. It also holds a one-deep pending-command slot and produces a status LED and a command-error strobe.

Parameters:
NUM_TRACKS, 4, number of selectable songs (1..127); track select width TRK_W = max(1, clog2(NUM_TRACKS)).
FINISH_MODE, 0, 0 = stop/switch cuts the song at once; 1 = current song always plays to completion first.
GAP_CYCLES, 1, cycles o_song_enable is held low between songs on restart/switch (>=1).

Ports:
i_clk  in  1  system clock; single clock domain.
i_rst  in  1  synchronous reset, active-high.
i_rx_data  in  8  byte from uart_rx; valid only when i_rx_valid=1.
i_rx_valid  in  1  one-cycle strobe, synchronous to i_clk, marking a new received byte.
i_song_done  in  1  engine completion level; a rising edge while o_song_enable=1 means the song has ended.
o_song_enable  out  1  engine enable; engine plays while high and resets when low.
o_song_sel  out  TRK_W  selected track, 0-based; stable whenever o_song_enable=1.
o_busy  out  1  high in PLAY, STOPPING and GAP states.
o_led_n  out  1  active-low play indicator; equals ~o_busy.
o_cmd_err  out  1  one-cycle pulse on an undecodable byte.

Behaviour:
- Reset values: o_song_enable=0, o_song_sel=0, o_busy=0, o_led_n=1, o_cmd_err=0.
- Reset internals: state=IDLE, loop flag=0, pending slot empty, gap counter=0, done-edge register=0.
- Reset is honoured mid-song; o_song_enable is 0 on the cycle after i_rst is sampled.
- Command decode, applied only when i_rx_valid=1:
  - 0x00 = STOP.
  - bits[6:0] = k with 1<=k<=NUM_TRACKS = PLAY track k-1; bit7 = LOOP flag.
  - Any other byte: pulse o_cmd_err for 1 cycle; no state change.
- Done event = i_song_done rising edge (registered previous value), counted only while o_song_enable=1.
- IDLE:
  - PLAY cmd: latch sel=k-1 and loop=bit7, go to PLAY; o_song_enable=1 on the next cycle (1-cycle latency).
  - STOP: ignored.
- PLAY (o_song_enable=1):
  - Done event with loop=1: go to GAP (restart same track).
  - Done event with loop=0: go to IDLE.
  - STOP with FINISH_MODE=0: go to IDLE; enable low next cycle.
  - STOP with FINISH_MODE=1: clear loop and empty the pending slot, go to STOPPING.
  - PLAY cmd with FINISH_MODE=0: latch new sel/loop, go to GAP.
  - PLAY cmd with FINISH_MODE=1: write the pending slot (a newer cmd overwrites an older one), clear loop.
  - Done event while a pending cmd is held: load sel/loop from the slot, empty it, go to GAP.
- STOPPING: enable stays high; on a done event go to IDLE. A PLAY cmd here goes to the pending slot and is taken on done, as in PLAY.
- GAP:
  - o_song_enable=0 for exactly GAP_CYCLES cycles, then return to PLAY with enable=1.
  - A PLAY cmd during GAP updates sel/loop; the counter is not restarted.
  - STOP during GAP goes to IDLE.
- Simultaneous cmd and done event in the same cycle:
  - With FINISH_MODE=0, the command wins; a PLAY cmd goes to GAP with the new track.
  - With FINISH_MODE=1, a PLAY cmd is treated as pending and consumed in that same cycle; a STOP goes to IDLE.
- o_song_sel changes only while o_song_enable=0, or in the cycle enable rises.

Decomposition:
- audio_pkg holds:
  - CMD_STOP=8'h00, CMD_LOOP_BIT=7, CMD_TRK_MSB=6.
  - State encoding IDLE/PLAY/STOPPING/GAP.
  - Command-kind typedef CMD_NONE/CMD_PLAY/CMD_STOP/CMD_BAD.
- Sub-module audio_cmd_decode: registered byte-to-{kind, track, loop} decoder plus o_cmd_err generation. Its latency of 1 cycle is included in the PLAY-to-enable latency budget; the FSM consumes its output.

Test Plan:
- Reset, then byte 0x02 (NUM_TRACKS=4, FINISH_MODE=0) -> o_song_sel=1 and o_song_enable=1 within 2 cycles of i_rx_valid; o_led_n=0.
- Playing track 0 non-loop, raise i_song_done -> enable=0 next cycle, state IDLE, o_led_n=1; a second done edge has no effect.
- Byte 0x83 then done edge -> enable low for exactly GAP_CYCLES=3 cycles, then high with sel=2.
- FINISH_MODE=1, playing track 0, send 0x00 then 0x04 before done -> enable stays 1 until done, then GAP, then sel=3 playing.
- Bytes 0x05, 0x7F, 0xFF (NUM_TRACKS=4) -> three single-cycle o_cmd_err pulses; outputs otherwise unchanged.
- i_rst asserted mid-PLAY together with i_rx_valid=0x01 -> all outputs at reset values next cycle; command discarded.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the Bluetooth command playback controller:
// command byte layout, FSM state encoding and decoded command kinds.
package audio_pkg;

  localparam logic [7:0] CMD_STOP_BYTE = 8'h00;
  localparam int         CMD_LOOP_BIT  = 7;
  localparam int         CMD_TRK_MSB   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_STOPPING,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_PLAY,
    CMD_STOP,
    CMD_BAD
  } cmd_kind_t;

  // Track-select width: clog2 of the track count, never narrower than 1 bit.
  function automatic int trk_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_cmd_decode.sv
// Registered decoder turning a received UART byte into {kind, track, loop}
// and a one-cycle error pulse for bytes that are not a valid command.
module audio_cmd_decode
  import audio_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int TRK_W      = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output cmd_kind_t        kind,
  output logic [TRK_W-1:0] trk,
  output logic             loop,
  output logic             cmd_err
);

  localparam int                KW    = CMD_TRK_MSB + 1;
  localparam logic [KW-1:0]     MAX_K = KW'(NUM_TRACKS);

  logic [KW-1:0] k;
  cmd_kind_t     kind_d;

  assign k = rx_data[CMD_TRK_MSB:0];

  // 0x80 has k=0 but is not the stop byte, so it falls through to BAD.
  always_comb begin
    kind_d = CMD_NONE;
    if (rx_valid) begin
      if (rx_data == CMD_STOP_BYTE) begin
        kind_d = CMD_STOP;
      end else if ((k != '0) && (k <= MAX_K)) begin
        kind_d = CMD_PLAY;
      end else begin
        kind_d = CMD_BAD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kind    <= CMD_NONE;
      trk     <= '0;
      loop    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      kind    <= kind_d;
      trk     <= TRK_W'(k - KW'(1));
      loop    <= rx_data[CMD_LOOP_BIT];
      cmd_err <= (kind_d == CMD_BAD);
    end
  end

endmodule

// File: rtl/audio_cmd_ctrl.sv
// Playback controller: turns decoded play/loop/stop commands into engine
// enable and track select, with cut-now or finish-first stop policy.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | engine disabled, waiting for a PLAY command
//   ST_PLAY     | engine enabled, current song playing
//   ST_STOPPING | engine enabled, song finishing after a STOP (finish mode)
//   ST_GAP      | engine held low between songs, gap down-counter running
module audio_cmd_ctrl
  import audio_pkg::*;
#(
  parameter  int NUM_TRACKS  = 4,
  parameter  int FINISH_MODE = 0,
  parameter  int GAP_CYCLES  = 1,
  localparam int TRK_W       = trk_width(NUM_TRACKS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_song_done,
  output logic             o_song_enable,
  output logic [TRK_W-1:0] o_song_sel,
  output logic             o_busy,
  output logic             o_led_n,
  output logic             o_cmd_err
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  cmd_kind_t        dec_kind;
  logic [TRK_W-1:0] dec_trk;
  logic             dec_loop;

  state_t           state_q, state_d;
  logic [TRK_W-1:0] sel_q, sel_d;
  logic             loop_q, loop_d;
  logic             pend_vld_q, pend_vld_d;
  logic [TRK_W-1:0] pend_trk_q, pend_trk_d;
  logic             pend_loop_q, pend_loop_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_q;

  logic song_en;
  logic done_evt;
  logic cmd_play;
  logic cmd_stop;

  audio_cmd_decode #(
    .NUM_TRACKS (NUM_TRACKS),
    .TRK_W      (TRK_W)
  ) u_decode (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .rx_data  (i_rx_data),
    .rx_valid (i_rx_valid),
    .kind     (dec_kind),
    .trk      (dec_trk),
    .loop     (dec_loop),
    .cmd_err  (o_cmd_err)
  );

  assign song_en  = (state_q == ST_PLAY) || (state_q == ST_STOPPING);
  assign done_evt = i_song_done && !done_q && song_en;
  assign cmd_play = (dec_kind == CMD_PLAY);
  assign cmd_stop = (dec_kind == CMD_STOP);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    loop_d      = loop_q;
    pend_vld_d  = pend_vld_q;
    pend_trk_d  = pend_trk_q;
    pend_loop_d = pend_loop_q;
    gap_d       = gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_play) begin
          sel_d   = dec_trk;
          loop_d  = dec_loop;
          state_d = ST_PLAY;
        end
      end

      ST_PLAY, ST_STOPPING: begin
        if (FINISH_MODE == 0) begin
          if (cmd_stop) begin
            state_d = ST_IDLE;
          end else if (cmd_play) begin
            sel_d   = dec_trk;
            loop_d  = dec_loop;
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (done_evt) begin
            if (loop_q) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          if (cmd_stop) begin
            loop_d     = 1'b0;
            pend_vld_d = 1'b0;
            state_d    = done_evt ? ST_IDLE : ST_STOPPING;
          end else if (cmd_play) begin
            // A play arriving with the done edge is queued and consumed at once.
            if (done_evt) begin
              sel_d      = dec_trk;
              loop_d     = dec_loop;
              pend_vld_d = 1'b0;
              state_d    = ST_GAP;
              gap_d      = GAP_LOAD;
            end else begin
              pend_vld_d  = 1'b1;
              pend_trk_d  = dec_trk;
              pend_loop_d = dec_loop;
              loop_d      = 1'b0;
            end
          end else if (done_evt) begin
            if (pend_vld_q) begin
              sel_d      = pend_trk_q;
              loop_d     = pend_loop_q;
              pend_vld_d = 1'b0;
              state_d    = ST_GAP;
              gap_d      = GAP_LOAD;
            end else if (loop_q) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_GAP: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else begin
          if (cmd_play) begin
            sel_d  = dec_trk;
            loop_d = dec_loop;
          end
          if (gap_q == '0) begin
            state_d = ST_PLAY;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      loop_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_trk_q  <= '0;
      pend_loop_q <= 1'b0;
      gap_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      loop_q      <= loop_d;
      pend_vld_q  <= pend_vld_d;
      pend_trk_q  <= pend_trk_d;
      pend_loop_q <= pend_loop_d;
      gap_q       <= gap_d;
      done_q      <= i_song_done;
    end
  end

  assign o_song_enable = song_en;
  assign o_song_sel    = sel_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_led_n       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_audio_cmd_ctrl.sv
// Bench for audio_cmd_ctrl: a cut-mode (gap 3) and a finish-mode (gap 2)
// instance, directed scenarios plus random traffic against a song-level model.
module tb_audio_cmd_ctrl;

  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rxd [2];
  logic       rxv [2];
  logic       dn  [2];

  wire [1:0] en, busy, led, err;
  wire [1:0] sel0, sel1;

  audio_cmd_ctrl #(.NUM_TRACKS(NT), .FINISH_MODE(0), .GAP_CYCLES(3)) u_cut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rxd[0]), .i_rx_valid(rxv[0]),
    .i_song_done(dn[0]), .o_song_enable(en[0]), .o_song_sel(sel0),
    .o_busy(busy[0]), .o_led_n(led[0]), .o_cmd_err(err[0]));

  audio_cmd_ctrl #(.NUM_TRACKS(NT), .FINISH_MODE(1), .GAP_CYCLES(2)) u_fin (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rxd[1]), .i_rx_valid(rxv[1]),
    .i_song_done(dn[1]), .o_song_enable(en[1]), .o_song_sel(sel1),
    .o_busy(busy[1]), .o_led_n(led[1]), .o_cmd_err(err[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int finish_mode(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int gap_len(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic int out_sel(input int i);
    return (i == 0) ? int'(sel0) : int'(sel1);
  endfunction

  // Song-level model: engine on/off, gap cycles left, current and queued song.
  int m_en   [2];
  int m_gap  [2];
  int m_sel  [2];
  int m_loop [2];
  int m_pend [2];   // queued track, -1 when nothing queued
  int m_pl   [2];
  int m_ck   [2];   // command seen by controller this cycle: 0 none,1 play,2 stop,3 bad
  int m_ct   [2];
  int m_cl   [2];
  int m_err  [2];
  int m_pdn  [2];
  bit chk_on = 1'b0;

  task automatic start_gap(input int i);
    m_en[i]  = 0;
    m_gap[i] = gap_len(i);
  endtask

  task automatic model_step(input int i);
    int kind, trk, lp, b, k;
    bit dev;
    if (rst) begin
      m_en[i] = 0; m_gap[i] = 0; m_sel[i] = 0; m_loop[i] = 0; m_pend[i] = -1;
      m_pl[i] = 0; m_ck[i] = 0; m_ct[i] = 0; m_cl[i] = 0; m_err[i] = 0; m_pdn[i] = 0;
    end else begin
      dev = (dn[i] == 1'b1) && (m_pdn[i] == 0) && (m_en[i] == 1);
      m_pdn[i] = int'(dn[i]);
      kind = m_ck[i]; trk = m_ct[i]; lp = m_cl[i];
      if (m_en[i] == 0 && m_gap[i] == 0) begin
        if (kind == 1) begin m_sel[i] = trk; m_loop[i] = lp; m_en[i] = 1; end
      end else if (m_gap[i] > 0) begin
        if (kind == 2) m_gap[i] = 0;
        else begin
          if (kind == 1) begin m_sel[i] = trk; m_loop[i] = lp; end
          m_gap[i]--;
          if (m_gap[i] == 0) m_en[i] = 1;
        end
      end else if (finish_mode(i) == 0) begin
        if (kind == 2) m_en[i] = 0;
        else if (kind == 1) begin m_sel[i] = trk; m_loop[i] = lp; start_gap(i); end
        else if (dev) begin
          if (m_loop[i] != 0) start_gap(i); else m_en[i] = 0;
        end
      end else begin
        if (kind == 2) begin
          m_loop[i] = 0; m_pend[i] = -1;
          if (dev) m_en[i] = 0;
        end else if (kind == 1) begin
          if (dev) begin m_sel[i] = trk; m_loop[i] = lp; m_pend[i] = -1; start_gap(i); end
          else begin m_pend[i] = trk; m_pl[i] = lp; m_loop[i] = 0; end
        end else if (dev) begin
          if (m_pend[i] >= 0) begin
            m_sel[i] = m_pend[i]; m_loop[i] = m_pl[i]; m_pend[i] = -1; start_gap(i);
          end else if (m_loop[i] != 0) start_gap(i);
          else m_en[i] = 0;
        end
      end
      if (m_en[i] == 0 && m_gap[i] == 0) m_pend[i] = -1;
      // byte seen now becomes next cycle's command
      b = int'(rxd[i]);
      k = b % 128;
      if (!rxv[i]) m_ck[i] = 0;
      else if (b == 0) m_ck[i] = 2;
      else if (k >= 1 && k <= NT) m_ck[i] = 1;
      else m_ck[i] = 3;
      m_ct[i]  = k - 1;
      m_cl[i]  = b / 128;
      m_err[i] = (m_ck[i] == 3) ? 1 : 0;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (rst) chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_en[%0d]", i),   int'(en[i]),   m_en[i]);
        chk($sformatf("model_sel[%0d]", i),  out_sel(i),    m_sel[i]);
        chk($sformatf("model_busy[%0d]", i), int'(busy[i]), (m_en[i] != 0 || m_gap[i] > 0) ? 1 : 0);
        chk($sformatf("model_led[%0d]", i),  int'(led[i]),  (m_en[i] != 0 || m_gap[i] > 0) ? 0 : 1);
        chk($sformatf("model_err[%0d]", i),  int'(err[i]),  m_err[i]);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    rxd[i] = b;
    rxv[i] = 1'b1;
    cyc();
    rxv[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin rxd[i] = 8'h00; rxv[i] = 1'b0; dn[i] = 1'b0; end
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      chk("rst_en", int'(en[i]), 0);
      chk("rst_sel", out_sel(i), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_led", int'(led[i]), 1);
      chk("rst_err", int'(err[i]), 0);
    end
    rst = 1'b0;
    cyc();

    // cut mode: play track 1
    send(0, 8'h02); cyc();
    chk("play_en", int'(en[0]), 1);
    chk("play_sel", out_sel(0), 1);
    chk("play_led", int'(led[0]), 0);

    // switch to track 0 goes through a 3-cycle gap
    send(0, 8'h01); cyc();
    chk("switch_gap", int'(en[0]), 0);
    cyc(3);
    chk("switch_en", int'(en[0]), 1);
    chk("switch_sel", out_sel(0), 0);

    // non-loop song ends, second done edge ignored
    dn[0] = 1'b1; cyc();
    chk("done_en", int'(en[0]), 0);
    chk("done_led", int'(led[0]), 1);
    dn[0] = 1'b0; cyc();
    dn[0] = 1'b1; cyc(2);
    chk("done2_en", int'(en[0]), 0);
    chk("done2_busy", int'(busy[0]), 0);

    // loop track 2: done restarts after exactly 3 low cycles
    dn[0] = 1'b0;
    send(0, 8'h83); cyc();
    chk("loop_en", int'(en[0]), 1);
    chk("loop_sel", out_sel(0), 2);
    dn[0] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cyc();
      chk("loop_gap_low", int'(en[0]), 0);
      chk("loop_gap_busy", int'(busy[0]), 1);
    end
    cyc();
    chk("loop_restart_en", int'(en[0]), 1);
    chk("loop_restart_sel", out_sel(0), 2);
    dn[0] = 1'b0;

    // undecodable bytes: single-cycle error pulses only
    begin
      logic [7:0] bad [3];
      bad[0] = 8'h05; bad[1] = 8'h7F; bad[2] = 8'hFF;
      for (int j = 0; j < 3; j++) begin
        send(0, bad[j]);
        chk("err_pulse", int'(err[0]), 1);
        cyc();
        chk("err_clear", int'(err[0]), 0);
        chk("err_en", int'(en[0]), 1);
        chk("err_sel", out_sel(0), 2);
      end
    end

    // reset mid-play with a command on the same cycle
    rxd[0] = 8'h01; rxv[0] = 1'b1; rst = 1'b1;
    cyc();
    chk("midrst_en", int'(en[0]), 0);
    chk("midrst_sel", out_sel(0), 0);
    chk("midrst_led", int'(led[0]), 1);
    chk("midrst_err", int'(err[0]), 0);
    rst = 1'b0; rxv[0] = 1'b0;
    cyc(2);
    chk("midrst_discard", int'(en[0]), 0);

    // finish mode: stop then play 4 before done
    send(1, 8'h01); cyc();
    chk("fin_play_en", int'(en[1]), 1);
    chk("fin_play_sel", out_sel(1), 0);
    send(1, 8'h00); cyc(2);
    chk("fin_stop_hold", int'(en[1]), 1);
    send(1, 8'h04); cyc(2);
    chk("fin_pend_en", int'(en[1]), 1);
    chk("fin_pend_sel", out_sel(1), 0);
    dn[1] = 1'b1; cyc();
    chk("fin_gap0", int'(en[1]), 0);
    cyc();
    chk("fin_gap1", int'(en[1]), 0);
    cyc();
    chk("fin_next_en", int'(en[1]), 1);
    chk("fin_next_sel", out_sel(1), 3);
    dn[1] = 1'b0;

    // finish mode: play command and done edge in the same cycle
    send(1, 8'h02);
    dn[1] = 1'b1; cyc();
    chk("sim_gap0", int'(en[1]), 0);
    cyc();
    chk("sim_gap1", int'(en[1]), 0);
    cyc();
    chk("sim_en", int'(en[1]), 1);
    chk("sim_sel", out_sel(1), 1);
    dn[1] = 1'b0;
    cyc();

    // random traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rxv[i] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 9))
          0:             rxd[i] = 8'h00;
          1, 2, 3, 4, 5: rxd[i] = {1'($urandom_range(0, 1)), 7'($urandom_range(1, NT))};
          default:       rxd[i] = 8'($urandom);
        endcase
        if ($urandom_range(0, 5) == 0) dn[i] = ~dn[i];
      end
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    rxv[0] = 1'b0; rxv[1] = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
